// File: rtl/instr_mem_loader_if.sv
// Byte-stream source and instruction-memory write port bundle for instr_mem_loader.
// The master modport is the byte source and memory side; the slave modport is the loader.
interface instr_mem_loader_if #(
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic                  in_valid_i;
  logic [7:0]            in_data_i;
  logic                  in_ready_o;
  logic                  we_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [31:0]           wdata_o;

  modport master (
    output in_valid_i,
    output in_data_i,
    input  in_ready_o,
    input  we_o,
    input  waddr_o,
    input  wdata_o
  );

  modport slave (
    input  in_valid_i,
    input  in_data_i,
    output in_ready_o,
    output we_o,
    output waddr_o,
    output wdata_o
  );
endinterface

// File: rtl/instr_mem_loader.sv
// Loads a length-prefixed little-endian word image into instruction memory, then releases CPU reset.
// Optional trailing checksum byte enabled by defining LOADER_CHECKSUM_EN.
module instr_mem_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  instr_mem_loader_if.slave bus_io,
  output logic              cpu_rst_n_o,
  output logic              done_o,
  output logic              err_o
);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StChk, StFlush, StDone, StErr} state_e;
  localparam state_e StAfterData = StChk;
`else
  typedef enum logic [2:0] {StLenHi, StLenLo, StData, StFlush, StDone, StErr} state_e;
  localparam state_e StAfterData = StFlush;
`endif

  localparam logic [16:0] Capacity = 17'(1) << ADDR_WIDTH;

  state_e                r_state;
  logic [15:0]           r_len;
  logic [1:0]            r_byte_cnt;
  logic [23:0]           r_shift;
  logic [ADDR_WIDTH-1:0] r_word_idx;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_waddr;
  logic [31:0]           r_wdata;
  logic                  r_cpu_rst_n;
  logic                  r_done;
  logic                  r_err;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]            r_sum;
  logic [7:0]            w_sum_next;
`endif

  logic        w_accept;
  logic [15:0] w_len_full;
  logic [31:0] w_word;
  logic [16:0] w_idx_next;
  logic        w_last_word;

  // Gated by rst_i so the source sees no readiness while reset is held.
  assign bus_io.in_ready_o = ~rst_i & ~(r_state inside {StFlush, StDone, StErr});
  assign w_accept          = bus_io.in_valid_i & bus_io.in_ready_o;
  assign w_len_full        = {r_len[15:8], bus_io.in_data_i};
  assign w_word            = {bus_io.in_data_i, r_shift};
  assign w_idx_next        = 17'(r_word_idx) + 17'd1;
  assign w_last_word       = (w_idx_next == {1'b0, r_len});
`ifdef LOADER_CHECKSUM_EN
  assign w_sum_next        = r_sum + bus_io.in_data_i;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= StLenHi;
      r_len       <= '0;
      r_byte_cnt  <= '0;
      r_shift     <= '0;
      r_word_idx  <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_cpu_rst_n <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      r_sum       <= '0;
`endif
    end else begin
      r_we <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (w_accept) r_sum <= w_sum_next;
`endif
      unique case (r_state)
        StLenHi: if (w_accept) begin
          r_len[15:8] <= bus_io.in_data_i;
          r_state     <= StLenLo;
        end
        StLenLo: if (w_accept) begin
          r_len[7:0] <= bus_io.in_data_i;
          if (17'(w_len_full) > Capacity) r_state <= StErr;
          else if (w_len_full == 16'd0)   r_state <= StAfterData;
          else                            r_state <= StData;
        end
        StData: if (w_accept) begin
          r_byte_cnt <= r_byte_cnt + 2'd1;
          r_shift    <= w_word[31:8];
          if (r_byte_cnt == 2'd3) begin
            r_we       <= 1'b1;
            r_waddr    <= r_word_idx;
            r_wdata    <= w_word;
            r_word_idx <= w_idx_next[ADDR_WIDTH-1:0];
            if (w_last_word) r_state <= StAfterData;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        StChk: if (w_accept) begin
          r_state <= (w_sum_next == 8'd0) ? StFlush : StErr;
        end
`endif
        // Lets the final write land before the CPU leaves reset.
        StFlush: r_state <= StDone;
        StDone: begin
          if (load_i) begin
            r_state     <= StLenHi;
            r_cpu_rst_n <= 1'b0;
            r_done      <= 1'b0;
            r_word_idx  <= '0;
            r_byte_cnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum       <= '0;
`endif
          end else begin
            r_cpu_rst_n <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        StErr: begin
          if (load_i) begin
            r_state    <= StLenHi;
            r_err      <= 1'b0;
            r_word_idx <= '0;
            r_byte_cnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_sum      <= '0;
`endif
          end else begin
            r_err <= 1'b1;
          end
        end
        default: r_state <= StLenHi;
      endcase
    end
  end

  assign bus_io.we_o    = r_we;
  assign bus_io.waddr_o = r_waddr;
  assign bus_io.wdata_o = r_wdata;
  assign cpu_rst_n_o    = r_cpu_rst_n;
  assign done_o         = r_done;
  assign err_o          = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader; expected writes come from a stream-parsing model.
module tb_instr_mem_loader;
  localparam int unsigned AW = 8;

  logic clk_i = 1'b0;
  logic rst_i;
  logic load_i;
  logic cpu_rst_n;
  logic done;
  logic err;

  instr_mem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  instr_mem_loader #(.ADDR_WIDTH(AW)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .load_i      (load_i),
    .bus_io      (bus),
    .cpu_rst_n_o (cpu_rst_n),
    .done_o      (done),
    .err_o       (err)
  );

  always #5 clk_i = ~clk_i;

  int n_total = 0;
  int n_pass  = 0;
  logic [7:0]    stream[$];
  logic [AW-1:0] exp_addr[$];
  logic [31:0]   exp_data[$];
  bit            exp_err;
  bit            load_noise;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual %0h required %0h at %0t", name, act, req, $time);
  endtask

  // Scoreboard monitor: every write strobe must match the oldest expected write.
  always @(negedge clk_i) begin
    if (bus.we_o !== 1'b0) begin
      if (exp_addr.size() == 0) begin
        check("unexpected_we", 32'(bus.we_o), 32'd0);
      end else begin
        logic [AW-1:0] a;
        logic [31:0]   d;
        a = exp_addr.pop_front();
        d = exp_data.pop_front();
        check("waddr", 32'(bus.waddr_o), 32'(a));
        check("wdata", bus.wdata_o, d);
      end
    end
  end

  // Reference model: parse the whole stream into the writes and outcome it implies.
  task automatic model_load();
    int unsigned n;
    n = {16'd0, stream[0], stream[1]};
    exp_err = 1'b0;
    if (n > (32'd1 << AW)) begin
      exp_err = 1'b1;
    end else begin
      for (int i = 0; i < int'(n); i++) begin
        int b;
        b = 2 + 4 * i;
        exp_addr.push_back(AW'(i));
        exp_data.push_back({stream[b+3], stream[b+2], stream[b+1], stream[b]});
      end
`ifdef LOADER_CHECKSUM_EN
      begin
        logic [7:0] sum;
        sum = 8'd0;
        foreach (stream[i]) sum += stream[i];
        if (sum != 8'd0) exp_err = 1'b1;
      end
`endif
    end
  endtask

  task automatic add_chk();
`ifdef LOADER_CHECKSUM_EN
    logic [7:0] sum;
    sum = 8'd0;
    foreach (stream[i]) sum += stream[i];
    stream.push_back(8'h00 - sum);
`endif
  endtask

  task automatic build_random(input int n);
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int i = 0; i < 4 * n; i++) stream.push_back(8'($urandom));
    add_chk();
  endtask

  // Entered and left #1 after a rising edge.
  task automatic send_byte(input logic [7:0] b, input int idle_lo, input int idle_hi);
    int   idle;
    logic rdy;
    bit   acc;
    acc  = 1'b0;
    idle = int'($urandom_range(idle_hi, idle_lo));
    repeat (idle) begin
      @(posedge clk_i);
      #1;
    end
    bus.in_valid_i = 1'b1;
    bus.in_data_i  = b;
    load_i         = load_noise ? 1'($urandom) : 1'b0;
    @(negedge clk_i);
    rdy = bus.in_ready_o;
    check("in_ready", 32'(rdy), 32'd1);
    for (int t = 0; t < 16 && !acc; t++) begin
      if (t > 0) begin
        @(negedge clk_i);
        rdy = bus.in_ready_o;
      end
      @(posedge clk_i);
      #1;
      acc = rdy;
    end
    bus.in_valid_i = 1'b0;
    load_i         = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_stream(input int idle_lo, input int idle_hi);
    model_load();
    foreach (stream[i]) send_byte(stream[i], idle_lo, idle_hi);
    @(negedge clk_i);
    if (!exp_err) check("done_early_k", 32'(done), 32'd0);
    @(negedge clk_i);
    if (exp_err) begin
      check("err_set", 32'(err), 32'd1);
      check("err_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
      check("err_in_ready", 32'(bus.in_ready_o), 32'd0);
      check("err_done", 32'(done), 32'd0);
    end else begin
      check("done_early_k1", 32'(done), 32'd0);
      check("cpu_rst_early_k1", 32'(cpu_rst_n), 32'd0);
      @(negedge clk_i);
      check("done_set", 32'(done), 32'd1);
      check("cpu_rst_n_set", 32'(cpu_rst_n), 32'd1);
      check("done_err", 32'(err), 32'd0);
      check("done_in_ready", 32'(bus.in_ready_o), 32'd0);
    end
    check("pending_writes", 32'(exp_addr.size()), 32'd0);
    @(posedge clk_i);
    #1;
  endtask

  task automatic restart();
    load_i = 1'b1;
    @(posedge clk_i);
    #1;
    load_i = 1'b0;
    @(negedge clk_i);
    check("restart_done", 32'(done), 32'd0);
    check("restart_err", 32'(err), 32'd0);
    check("restart_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("restart_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] w0;
    logic [31:0] w1;
    rst_i          = 1'b1;
    load_i         = 1'b0;
    load_noise     = 1'b0;
    bus.in_valid_i = 1'b0;
    bus.in_data_i  = 8'h00;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_in_ready", 32'(bus.in_ready_o), 32'd0);
    check("rst_we", 32'(bus.we_o), 32'd0);
    check("rst_waddr", 32'(bus.waddr_o), 32'd0);
    check("rst_wdata", bus.wdata_o, 32'd0);
    check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("post_rst_in_ready", 32'(bus.in_ready_o), 32'd1);
    @(posedge clk_i);
    #1;

    // Reference image at full rate, then with valid toggling.
    stream = '{8'h00, 8'h02, 8'h05, 8'h00, 8'h01, 8'h20, 8'h0A, 8'h00, 8'h02, 8'h20};
    add_chk();
    run_stream(0, 0);
    restart();
    stream = '{8'h00, 8'h02, 8'h05, 8'h00, 8'h01, 8'h20, 8'h0A, 8'h00, 8'h02, 8'h20};
    add_chk();
    run_stream(1, 1);
    restart();

    // Empty image.
    stream = '{8'h00, 8'h00};
    add_chk();
    run_stream(0, 0);
    restart();

    // Count overflow, then recovery.
    stream = '{8'h01, 8'h01};
    run_stream(0, 0);
    restart();
    build_random(1);
    run_stream(0, 2);
    restart();

`ifdef LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'hD9};
    run_stream(0, 0);
    restart();
    stream = '{8'h00, 8'h01, 8'h05, 8'h00, 8'h01, 8'h20, 8'hDA};
    run_stream(0, 0);
    restart();
`endif

    // Random images with idle gaps and load_i noise mid-stream.
    for (int it = 0; it < 6; it++) begin
      load_noise = 1'b1;
      build_random(int'($urandom_range(8, 1)));
      run_stream(0, 2);
      load_noise = 1'b0;
      restart();
    end

    // Full capacity: last word lands at the top address.
    build_random(1 << AW);
    run_stream(0, 0);
    restart();

    // Reset two bytes into word 1: only word 0 is written.
    w0 = $urandom;
    w1 = $urandom;
    exp_addr.push_back(AW'(0));
    exp_data.push_back(w0);
    stream = '{8'h00, 8'h03};
    for (int i = 0; i < 4; i++) stream.push_back(8'(w0 >> (8 * i)));
    stream.push_back(w1[7:0]);
    stream.push_back(w1[15:8]);
    foreach (stream[i]) send_byte(stream[i], 0, 0);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("midrst_in_ready", 32'(bus.in_ready_o), 32'd0);
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(negedge clk_i);
    check("midrst_we", 32'(bus.we_o), 32'd0);
    check("midrst_waddr", 32'(bus.waddr_o), 32'd0);
    check("midrst_wdata", bus.wdata_o, 32'd0);
    check("midrst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
    check("midrst_in_ready_after", 32'(bus.in_ready_o), 32'd1);
    check("midrst_pending", 32'(exp_addr.size()), 32'd0);
    repeat (4) @(posedge clk_i);
    #1;
    build_random(3);
    run_stream(0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Byte-stream program loader that fills the CPU instruction memory from an external source and holds the CPU in reset until loading completes. It receives a length-prefixed, little-endian word image over a valid/ready byte interface and drives a single-word write port into the instruction memory. It then releases the CPU's active-low reset. This is the write side of instruction memory, replacing file preload when running on hardware.

## Interface
- ADDR_WIDTH, 8: word-address width of instruction memory; capacity 2^ADDR_WIDTH words.
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- load_i  in  1  restart pulse; honoured only in DONE or ERR.
- in_valid_i  in  1  source byte valid.
- in_data_i  in  8  source byte.
- in_ready_o  out  1  loader accepts byte; transfer = in_valid_i & in_ready_o at rising edge.
- we_o  out  1  instruction-memory write strobe, one cycle per word.
- waddr_o  out  ADDR_WIDTH  word address (byte address >> 2).
- wdata_o  out  32  instruction word.
- cpu_rst_n_o  out  1  drives CPU rst_n; 0 = CPU held in reset.
- done_o  out  1  image loaded, CPU running.
- err_o  out  1  load failed.

## Operation
- Stream format: LEN_HI, LEN_LO (16-bit word count N, big-endian), then N words of 4 bytes each, least-significant byte first (byte 0 → wdata[7:0]). With LOADER_CHECKSUM_EN, one checksum byte follows.
- States: LEN_HI → LEN_LO → DATA → (CHK) → FLUSH → DONE; ERR.
- LEN_HI / LEN_LO: capture the count. At the LEN_LO accept:
  - N > 2^ADDR_WIDTH → ERR.
  - N == 0 → CHK if enabled, else FLUSH.
  - otherwise → DATA.
- DATA:
  - 2-bit byte counter assembles a shift register.
  - On the 4th byte accept: register wdata_o and waddr_o, and pulse we_o in the next cycle.
  - Word index starts at 0 and increments per word; it does not wrap, because the count check excludes overflow.
  - After word N-1 → CHK or FLUSH.
- FLUSH: one cycle so the final we_o completes before reset release, then → DONE.
- DONE: cpu_rst_n_o=1, done_o=1, in_ready_o=0. load_i → LEN_HI, which deasserts cpu_rst_n_o and done_o.
- ERR: err_o=1, cpu_rst_n_o=0, in_ready_o=0. load_i → LEN_HI and clears err_o.
- in_ready_o=1 exactly in LEN_HI, LEN_LO, DATA, CHK. The loader never back-pressures mid-word; the source may idle (in_valid_i=0) between any bytes.
- load_i is ignored outside DONE/ERR.

## Timing
- Reset values (while rst_i=1 and the cycle after): state LEN_HI; in_ready_o=0 during reset, 1 from the first cycle after release; we_o=0, waddr_o=0, wdata_o=0, cpu_rst_n_o=0, done_o=0, err_o=0; byte counter, word index and checksum accumulator = 0.
- Write latency: we_o high for exactly 1 cycle, in the cycle after the 4th byte of a word is accepted. Back-to-back words at one byte per cycle give a we_o pulse every 4 cycles.
- Last data byte accepted at edge k, checksum disabled: we_o high in cycle k+1 (FLUSH); cpu_rst_n_o=1 and done_o=1 from edge k+2.
- Checksum enabled: the last word's we_o occurs in the first CHK cycle. The checksum byte is accepted at edge m; cpu_rst_n_o/done_o go high from edge m+2 on success. On failure, err_o=1 from edge m+1.
- Restart (load_i at edge j in DONE/ERR): cpu_rst_n_o=0, done_o=0, err_o=0 from edge j; in_ready_o=1 in the following cycle.
- Reset mid-load: everything returns to reset values on the next edge. A partial word is discarded and never written. Words already written stay in memory.

## Configuration
- LOADER_CHECKSUM_EN defined:
  - An 8-bit accumulator sums every accepted byte, modulo 256, from LEN_HI through the checksum byte.
  - Total == 0x00 → FLUSH; otherwise → ERR.
- Not defined: no CHK state or accumulator. The stream ends after the last data byte, and ERR is reachable only by count overflow.

## Test plan
- Load N=2, bytes 00 02 05 00 01 20 0A 00 02 20 at 1 byte/cycle (no checksum) → we_o at addr 0 data 0x20010005, then at addr 1 data 0x2002000A; cpu_rst_n_o rises 2 edges after the last byte; done_o=1.
- Same image with in_valid_i toggling every other cycle → identical writes; in_ready_o stays 1 throughout; no extra we_o.
- N=0 (00 00) → no we_o; done_o=1 two edges after the LEN_LO accept.
- ADDR_WIDTH=8, N=257 (01 01) → err_o=1, cpu_rst_n_o stays 0, in_ready_o=0. A load_i pulse returns to LEN_HI, and N=1 then loads correctly.
- With LOADER_CHECKSUM_EN, N=1, word 0x20010005, checksum 0xD9 (byte sum 0x27+0xD9=0x100) → done_o=1. Checksum 0xDA → err_o=1, cpu_rst_n_o=0.
- rst_i asserted after 2 bytes of word 1 → no write for word 1; word 0 remains written. After reset release, a full fresh stream loads from addr 0.
